intc_sched: RTL and testbench

- Interrupt scheduler for the monocycle CPU.
- Captures requests from the four I/O port sources and latches them as pending.
- Arbitrates pending requests by priority and mask, then sequences one service at a time through a request/ack/finish handshake with the control unit (UC).
- Drives the 10-bit vector fed to the PC-select mux, and holds the vector stable for the whole service.

---
 rtl/intc_sched.sv | 153 +++++++++++++++
 tb/tb_intc_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_sched.sv
//==============================================================================
// Module   : intc_sched
// Brief    : Four-source interrupt scheduler. Synchronizes and latches I/O
//            requests, arbitrates by priority and mask, and sequences one
//            service at a time through a req/ack/fin handshake with the UC.
//            Optional macro INTC_PRIO_ROTATE_EN selects round-robin priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module intc_sched #(
    parameter int              PC_W      = 10,
    parameter logic [PC_W-1:0] VEC_BASE  = PC_W'('h3F0),
    parameter int              VEC_SHIFT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      irq,
    input  logic            mask_we,
    input  logic [3:0]      mask_d,
    input  logic            ack,
    input  logic            fin,
    output logic            int_req,
    output logic            int_active,
    output logic [PC_W-1:0] vector,
    output logic [1:0]      cur_id,
    output logic [3:0]      pending,
    output logic [3:0]      mask
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t          r_state;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_prev;
    logic [3:0]      r_pending;
    logic [3:0]      r_mask;
    logic [1:0]      r_cur_id;
    logic            r_int_req;
    logic            r_int_active;
    logic [PC_W-1:0] r_vector;
`ifdef INTC_PRIO_ROTATE_EN
    logic [1:0]      r_rp;
`endif

    logic [3:0]      w_rise;
    logic [3:0]      w_eligible;
    logic [3:0]      w_clr;
    logic [1:0]      w_win_id;
    logic [PC_W-1:0] w_win_vec;

    assign w_rise     = r_sync2 & ~r_prev;
    assign w_eligible = r_pending & ~r_mask;
    assign w_clr      = (r_state == ST_REQ && ack) ? (4'b0001 << r_cur_id) : 4'b0000;
    assign w_win_vec  = VEC_BASE + (PC_W'(w_win_id) << VEC_SHIFT);

    // Descending scan so the highest-priority eligible source is written last.
    always_comb begin
        w_win_id = 2'd0;
`ifdef INTC_PRIO_ROTATE_EN
        for (int k = 3; k >= 0; k--) begin
            if (w_eligible[r_rp + 2'(k)]) begin
                w_win_id = r_rp + 2'(k);
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (w_eligible[k]) begin
                w_win_id = 2'(k);
            end
        end
`endif
    end

    // Capture path; a new edge on the bit being acknowledged keeps it pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 4'b0000;
            r_sync2   <= 4'b0000;
            r_prev    <= 4'b0000;
            r_pending <= 4'b0000;
            r_mask    <= 4'b0000;
        end else begin
            r_sync1   <= irq;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (mask_we) begin
                r_mask <= mask_d;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_cur_id     <= 2'd0;
            r_int_req    <= 1'b0;
            r_int_active <= 1'b0;
            r_vector     <= VEC_BASE;
`ifdef INTC_PRIO_ROTATE_EN
            r_rp         <= 2'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_eligible) begin
                        r_state   <= ST_REQ;
                        r_int_req <= 1'b1;
                        r_cur_id  <= w_win_id;
                        r_vector  <= w_win_vec;
                    end
                end
                ST_REQ: begin
                    if (ack) begin
                        r_state      <= ST_SERV;
                        r_int_req    <= 1'b0;
                        r_int_active <= 1'b1;
`ifdef INTC_PRIO_ROTATE_EN
                        r_rp         <= r_cur_id + 2'd1;
`endif
                    end
                end
                ST_SERV: begin
                    if (fin) begin
                        r_state      <= ST_IDLE;
                        r_int_active <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_int_req    <= 1'b0;
                    r_int_active <= 1'b0;
                end
            endcase
        end
    end

    assign int_req    = r_int_req;
    assign int_active = r_int_active;
    assign vector     = r_vector;
    assign cur_id     = r_cur_id;
    assign pending    = r_pending;
    assign mask       = r_mask;

endmodule

`default_nettype wire

// File: tb/tb_intc_sched.sv
//==============================================================================
// Module   : tb_intc_sched
// Brief    : Scoreboard bench for intc_sched; service order comes from a
//            set-based priority model (round-robin when INTC_PRIO_ROTATE_EN).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_intc_sched;

    localparam int PC_W = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      irq = 4'b0;
    logic            mask_we = 1'b0;
    logic [3:0]      mask_d = 4'b0;
    logic            ack = 1'b0;
    logic            fin = 1'b0;
    logic            int_req;
    logic            int_active;
    logic [PC_W-1:0] vector;
    logic [1:0]      cur_id;
    logic [3:0]      pending;
    logic [3:0]      mask;

    intc_sched #(.PC_W(PC_W), .VEC_BASE(10'h3F0), .VEC_SHIFT(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_d     (mask_d),
        .ack        (ack),
        .fin        (fin),
        .int_req    (int_req),
        .int_active (int_active),
        .vector     (vector),
        .cur_id     (cur_id),
        .pending    (pending),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]      id;
        logic [PC_W-1:0] vec;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [3:0] m_pend  = 4'b0;
    logic [3:0] m_mask  = 4'b0;
    logic [1:0] m_rp    = 2'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    function automatic logic [1:0] pick(input logic [3:0] s);
`ifdef INTC_PRIO_ROTATE_EN
        for (int k = 0; k < 4; k++) if (s[(32'(m_rp) + k) % 4]) return 2'((32'(m_rp) + k) % 4);
`else
        for (int k = 0; k < 4; k++) if (s[k]) return 2'(k);
`endif
        return 2'd0;
    endfunction

    // Next service per the model; consumes the request from the model set.
    task automatic expect_next();
        logic [1:0] id;
        exp_t       e;
        id    = pick(m_pend & ~m_mask);
        e.id  = id;
        e.vec = 10'h3F0 + 10'(id) * 10'd4;
        exp_q.push_back(e);
        m_pend[id] = 1'b0;
        m_rp = id + 2'd1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [3:0] v);
        irq = irq | v;
        step();
        irq = irq & ~v;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_d  = m;
        mask_we = 1'b1;
        step();
        mask_we = 1'b0;
        m_mask  = m;
        chk("mask_reg", 32'(mask), 32'(m));
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!int_req && n < 50) begin
            step();
            n++;
        end
        chk("int_req_seen", 32'(int_req), 32'd1);
    endtask

    task automatic service_one(input logic [3:0] rep, input bit gap);
        int n;
        wait_req(n);
        if (gap) chk("idle_gap", 32'(n), 32'd1);
        chk("active_in_req", 32'(int_active), 32'd0);
        repeat ($urandom_range(0, 2)) step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("req_after_ack", 32'(int_req), 32'd0);
        chk("active_after_ack", 32'(int_active), 32'd1);
        if (rep != 4'b0) begin
            m_pend |= rep;
            pulse(rep);
            repeat (3) step();
        end else begin
            repeat ($urandom_range(0, 3)) step();
        end
        fin = 1'b1;
        step();
        fin = 1'b0;
    endtask

    task automatic burst(input logic [3:0] bits, input logic [3:0] m);
        int n;
        write_mask(m);
        m_pend |= bits;
        n = $countones(m_pend & ~m_mask);
        for (int i = 0; i < n; i++) expect_next();
        pulse(bits);
        for (int i = 0; i < n; i++) service_one(4'b0, i != 0);
        repeat (4) step();
        chk("held_no_req", 32'(int_req), 32'd0);
        chk("held_pending", 32'(pending), 32'(m_pend));
        write_mask(4'b0);
        n = $countones(m_pend);
        for (int i = 0; i < n; i++) expect_next();
        for (int i = 0; i < n; i++) service_one(4'b0, i != 0);
        chk("drained", 32'(pending), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each new request, then checks that
    // the id and vector hold until the service ends.
    initial begin
        exp_t       e;
        logic       mon_prev;
        logic [1:0] mon_id;
        logic [PC_W-1:0] mon_vec;
        mon_prev = 1'b0;
        mon_id   = 2'd0;
        mon_vec  = 10'h3F0;
        forever begin
            @(negedge clk);
            if (reset && int_req && !mon_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_req", 32'(int_req), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("cur_id", 32'(cur_id), 32'(e.id));
                    chk("vector", 32'(vector), 32'(e.vec));
                    mon_id  = e.id;
                    mon_vec = e.vec;
                end
            end else if (reset && (int_req || int_active)) begin
                chk("cur_id_frozen", 32'(cur_id), 32'(mon_id));
                chk("vector_frozen", 32'(vector), 32'(mon_vec));
            end
            mon_prev = reset & int_req;
        end
    end

    initial begin
        int n;
        repeat (2) step();
        chk("rst_int_req", 32'(int_req), 32'd0);
        chk("rst_int_active", 32'(int_active), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mask", 32'(mask), 32'd0);
        chk("rst_vector", 32'(vector), 32'h3F0);
        reset = 1'b1;
        step();

        // Stray ack/fin with nothing pending are ignored.
        ack = 1'b1; fin = 1'b1;
        step();
        ack = 1'b0; fin = 1'b0;
        chk("idle_ack_req", 32'(int_req), 32'd0);
        chk("idle_ack_active", 32'(int_active), 32'd0);

        // Single held request: pending appears two edges after first sample.
        m_pend |= 4'b0100;
        expect_next();
        irq = 4'b0100;
        step();
        chk("pend_k", 32'(pending), 32'd0);
        step();
        chk("pend_k1", 32'(pending), 32'd0);
        step();
        chk("pend_k2", 32'(pending), 32'b0100);
        service_one(4'b0, 1'b0);
        repeat (5) step();
        chk("held_level_no_req", 32'(int_req), 32'd0);
        chk("held_level_pending", 32'(pending), 32'd0);
        irq = 4'b0;
        repeat (3) step();

        // Two simultaneous sources.
        m_pend |= 4'b1010;
        expect_next();
        expect_next();
        pulse(4'b1010);
        service_one(4'b0, 1'b0);
        service_one(4'b0, 1'b1);

        // Masked source held, then released.
        burst(4'b0001, 4'b0001);

        // No preemption while in REQ.
        m_pend |= 4'b0100;
        expect_next();
        pulse(4'b0100);
        wait_req(n);
        m_pend |= 4'b0001;
        pulse(4'b0001);
        repeat (4) step();
        chk("nopreempt_id", 32'(cur_id), 32'd2);
        chk("nopreempt_vec", 32'(vector), 32'h3F8);
        expect_next();
        service_one(4'b0, 1'b0);
        service_one(4'b0, 1'b1);

        // New edge on the bit being acknowledged keeps it pending.
        m_pend |= 4'b0010;
        expect_next();
        pulse(4'b0010);
        wait_req(n);
        pulse(4'b0010);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("setwins_pending", 32'(pending), 32'b0010);
        chk("setwins_active", 32'(int_active), 32'd1);
        m_pend |= 4'b0010;
        expect_next();
        fin = 1'b1;
        step();
        fin = 1'b0;
        service_one(4'b0, 1'b1);

        // Sources 0 and 1 keep re-requesting during each service.
        m_pend |= 4'b0011;
        expect_next();
        pulse(4'b0011);
        service_one(4'b0011, 1'b0);
        repeat (3) begin
            expect_next();
            service_one(4'b0011, 1'b1);
        end
        while (m_pend != 4'b0) begin
            expect_next();
            service_one(4'b0, 1'b1);
        end

        // Asynchronous reset in the middle of a service.
        write_mask(4'b1000);
        m_pend |= 4'b0101;
        expect_next();
        pulse(4'b0101);
        wait_req(n);
        ack = 1'b1;
        step();
        ack = 1'b0;
        repeat (3) step();
        chk("pend_in_serv", 32'(pending), 32'(m_pend));
        #2 reset = 1'b0;
        #1;
        chk("arst_int_req", 32'(int_req), 32'd0);
        chk("arst_int_active", 32'(int_active), 32'd0);
        chk("arst_pending", 32'(pending), 32'd0);
        chk("arst_mask", 32'(mask), 32'd0);
        chk("arst_cur_id", 32'(cur_id), 32'd0);
        chk("arst_vector", 32'(vector), 32'h3F0);
        m_pend = 4'b0;
        m_mask = 4'b0;
        m_rp   = 2'd0;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        step();
        reset = 1'b1;
        step();

        for (int t = 0; t < 15; t++) begin
            burst(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)));
        end
        repeat (4) step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
